mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Memory-stage controller and MEM/WB pipeline register for the pipelined ARM-subset core. It sits at the receiving end of the EX/MEM register: it takes the M-stage control and data bundle and runs loads/stores against the data memory over a valid/ready request plus response-valid protocol. It stalls the upstream pipeline while an access is outstanding and registers the W-stage bundle.

Parameters:
TIMEOUT, 255, max cycles waited in RESP for MemRespValid before a load is aborted (range 1..65535)

Ports:
CLK  in  1  clock, all state on posedge
RESET  in  1  synchronous, active-high reset
PCSrcM  in  1  M-stage branch/PC-write flag
RegWriteM  in  1  M-stage register write enable
MemtoRegM  in  1  M-stage load (result comes from memory)
MemWriteM  in  1  M-stage store
ALUResultM  in  32  address / ALU result
WriteDataM  in  32  store data
WA3M  in  4  destination register
MemReqValid  out  1  request valid to data memory
MemReqReady  in  1  memory accepts request
MemAddr  out  32  request address (= ALUResultM)
MemWData  out  32  store data (= WriteDataM)
MemWE  out  1  1 = store, 0 = load (= MemWriteM)
MemRespValid  in  1  load data valid
MemRData  in  32  load data
StallM  out  1  hold F/D/E/M stages this cycle
PCSrcW  out  1  registered
RegWriteW  out  1  registered
MemtoRegW  out  1  registered
ReadDataW  out  32  registered load data
ALUOutW  out  32  registered ALUResultM
WA3W  out  4  registered
MemErr  out  1  sticky load-timeout flag

Behaviour:
- Access = MemtoRegM | MemWriteM. If both are set, the instruction is treated as a store.
- States: IDLE and RESP. Timeout counter is 16 bits.
- IDLE, no access:
  - MemReqValid=0, StallM=0.
  - Instruction completes this cycle; W regs load at the next edge (1-cycle latency, identical to a plain pipeline register).
- IDLE, access:
  - MemReqValid=1, with MemAddr/MemWData/MemWE driven combinationally from the M inputs.
  - Store, MemReqReady=1: complete this cycle, StallM=0, stay in IDLE.
  - Load, MemReqReady=1: StallM=1, go to RESP, counter cleared to 0.
  - MemReqReady=0: StallM=1, stay in IDLE, keep holding the request. Valid must not drop and the request fields must stay stable, because M inputs are frozen by StallM.
- RESP:
  - MemReqValid=0.
  - MemRespValid=1: complete this cycle. StallM=0, ReadDataW<=MemRData, go to IDLE.
  - Otherwise: StallM=1 and counter increments.
  - Counter reaches TIMEOUT-1 with no response: complete anyway. ReadDataW<=0, MemErr<=1, go to IDLE.
- MemRespValid in IDLE (late or spurious response) is ignored.
- StallM is combinational: StallM = access && !complete.
- W update on every edge:
  - Completing cycle: PCSrcW/RegWriteW/MemtoRegW/ALUOutW/WA3W <= M values. ReadDataW updates only on load completion and holds otherwise.
  - StallM=1: bubble. PCSrcW, RegWriteW and MemtoRegW <= 0; data outputs hold.
- Reset:
  - RESET high forces MemReqValid=0 and StallM=0 combinationally.
  - At the edge: state=IDLE, counter=0, and all W outputs plus MemErr go to 0.
  - Reset mid-RESP abandons the load. A response arriving afterwards is ignored.
- MemErr clears only on RESET.

Test Plan:
- ALU op (RegWriteM=1, ALUResultM=0x00000010, WA3M=3), no access -> next cycle ALUOutW=0x10, WA3W=3, RegWriteW=1; StallM never 1, MemReqValid never 1.
- Store to 0x100, data 0xCAFEF00D, MemReqReady low for 2 cycles then high -> MemReqValid=1 and StallM=1 for 2 cycles, address/data stable; handshake in cycle 3 with StallM=0; W bubbles (RegWriteW=0) during the stall cycles.
- Load from 0x200, ready immediately, MemRespValid after 3 cycles with 0x12345678 -> StallM high for 3 cycles; ReadDataW=0x12345678, MemtoRegW=1, RegWriteW=1 one edge after the response.
- Load with TIMEOUT=4 and no response -> abort after 4 RESP cycles; ReadDataW=0, MemErr=1 and held; a later MemRespValid pulse in IDLE has no effect.
- Back-to-back loads, each with a same-cycle MemReqReady and a 1-cycle response -> each completes; the second request is issued only after the first completes; no duplicate request for either address.
- RESET asserted during RESP -> next cycle state=IDLE, StallM=0, all W outputs 0, MemErr=0; a response arriving afterwards is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller and MEM/WB pipeline register.
//
// Takes the M-stage control/data bundle from the EX/MEM register and performs
// loads and stores against data memory. The request side is a valid/ready
// handshake, and load data returns later on a response-valid strobe. StallM holds
// the upstream stages while an access is pending. The W-stage bundle is
// registered on every edge, and a bubble is inserted while stalled.
//
// Ports:
//   CLK, RESET            clock; synchronous active-high reset
//   PCSrcM .. WA3M        M-stage control and data inputs
//   MemReqValid/Ready     request handshake; MemAddr/MemWData/MemWE request fields
//   MemRespValid/MemRData load response
//   StallM                hold F/D/E/M this cycle
//   PCSrcW .. WA3W        registered W-stage bundle
//   MemErr                sticky load-timeout flag, cleared only by RESET
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PCSrcM,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  WA3M,
   output logic        MemReqValid,
   input  logic        MemReqReady,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic        MemWE,
   input  logic        MemRespValid,
   input  logic [31:0] MemRData,
   output logic        StallM,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  WA3W,
   output logic        MemErr
);

   typedef enum logic [0:0] {StIdle, StResp} state_e;

   // Last RESP cycle count before a silent load is abandoned.
   localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;

   logic access;
   logic is_load;
   logic resp_ok;
   logic timeout_hit;
   logic complete;

   // A store that is also flagged as a load is handled as a store.
   assign access      = MemtoRegM | MemWriteM;
   assign is_load     = MemtoRegM & ~MemWriteM;
   assign resp_ok     = (state_q == StResp) && MemRespValid;
   // A response in the final cycle takes priority over the abort.
   assign timeout_hit = (state_q == StResp) && !MemRespValid && (cnt_q == CntLast);

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (access && is_load && MemReqReady) begin
               state_d = StResp;
               cnt_d   = '0;
            end
         end
         StResp: begin
            if (resp_ok || timeout_hit) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      complete    = 1'b0;
      MemReqValid = 1'b0;
      StallM      = 1'b0;
      case (state_q)
         StIdle: begin
            // Loads never finish in IDLE; they must pass through RESP.
            complete    = !access || (MemWriteM && MemReqReady);
            MemReqValid = access;
         end
         StResp: begin
            complete = resp_ok || timeout_hit;
         end
         default: complete = 1'b0;
      endcase
      StallM = !complete;
      if (RESET) begin
         MemReqValid = 1'b0;
         StallM      = 1'b0;
      end
   end

   // Request fields are driven straight from the M bundle. StallM freezes the M
   // bundle, so these fields stay stable while a request waits for ready.
   assign MemAddr  = ALUResultM;
   assign MemWData = WriteDataM;
   assign MemWE    = MemWriteM;

   // MEM/WB register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         PCSrcW    <= 1'b0;
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ReadDataW <= '0;
         ALUOutW   <= '0;
         WA3W      <= '0;
         MemErr    <= 1'b0;
      end else if (complete) begin
         PCSrcW    <= PCSrcM;
         RegWriteW <= RegWriteM;
         MemtoRegW <= MemtoRegM;
         ALUOutW   <= ALUResultM;
         WA3W      <= WA3M;
         if (resp_ok) begin
            ReadDataW <= MemRData;
         end else if (timeout_hit) begin
            ReadDataW <= '0;
            MemErr    <= 1'b1;
         end
      end else begin
         // Bubble: kill side-effecting flags and hold the data fields.
         PCSrcW    <= 1'b0;
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl. A transaction-level model predicts
// the cycle count, stall/valid pattern, and W-stage result of each instruction
// from its ready delay and its response delay.
module tb_mem_stage_ctrl;

   localparam int TO = 4;

   logic        CLK;
   logic        RESET;
   logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [3:0]  WA3M;
   logic        MemReqValid, MemReqReady;
   logic [31:0] MemAddr, MemWData;
   logic        MemWE;
   logic        MemRespValid;
   logic [31:0] MemRData;
   logic        StallM;
   logic        PCSrcW, RegWriteW, MemtoRegW;
   logic [31:0] ReadDataW, ALUOutW;
   logic [3:0]  WA3W;
   logic        MemErr;

   int errors = 0;
   int checks = 0;

   // Expected W-stage state
   logic        exp_pc, exp_rw, exp_m2r, exp_err;
   logic [31:0] exp_alu, exp_rd;
   logic [3:0]  exp_wa;

   mem_stage_ctrl #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET),
      .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .WA3M(WA3M), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
      .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE),
      .MemRespValid(MemRespValid), .MemRData(MemRData), .StallM(StallM),
      .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
      .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W), .MemErr(MemErr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Runs one instruction. Entry and exit happen 1 time unit after a posedge.
   // r    = cycles with MemReqReady low before the handshake
   // d    = RESP cycles before MemRespValid (d >= TO means no response)
   // spur = force MemRespValid high in cycles where it must be ignored
   task automatic do_instr(input logic pc, input logic rw, input logic m2r, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa,
                           input int r, input int d, input logic [31:0] rdata,
                           input logic spur, input string tag);
      logic acc, ld, ev, es;
      int   n, hs;
      acc = m2r | mw;
      ld  = m2r & ~mw;
      if (!acc)     n = 1;
      else if (!ld) n = r + 1;
      else          n = r + 1 + ((d < TO) ? d + 1 : TO);
      PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
      ALUResultM = alu; WriteDataM = wd; WA3M = wa;
      hs = 0;
      for (int k = 0; k < n; k++) begin
         if (!acc)        MemReqReady = 1'($urandom_range(0, 1));
         else if (k < r)  MemReqReady = 1'b0;
         else if (k == r) MemReqReady = 1'b1;
         else             MemReqReady = 1'($urandom_range(0, 1));
         if (ld && k > r) MemRespValid = (d < TO) && (k == r + 1 + d);
         else             MemRespValid = spur ? 1'b1 : 1'($urandom_range(0, 1));
         MemRData = (ld && k == r + 1 + d) ? rdata : $urandom;
         ev = acc && (k <= r);
         es = (k < n - 1);
         @(negedge CLK);
         checks++;
         if (MemReqValid !== ev) begin
            errors++;
            $display("FAIL %s req_valid k=%0d got=%b exp=%b", tag, k, MemReqValid, ev);
         end
         checks++;
         if (StallM !== es) begin
            errors++;
            $display("FAIL %s stall k=%0d got=%b exp=%b", tag, k, StallM, es);
         end
         if (ev) begin
            checks++;
            if (MemAddr !== alu || MemWData !== wd || MemWE !== mw) begin
               errors++;
               $display("FAIL %s req_fields k=%0d got=%h/%h/%b exp=%h/%h/%b", tag, k,
                        MemAddr, MemWData, MemWE, alu, wd, mw);
            end
         end
         if (MemReqValid === 1'b1 && MemReqReady) hs++;
         @(posedge CLK);
         #1;
         if (k == n - 1) begin
            exp_pc = pc; exp_rw = rw; exp_m2r = m2r; exp_alu = alu; exp_wa = wa;
            if (ld) begin
               if (d < TO) exp_rd = rdata;
               else begin
                  exp_rd  = '0;
                  exp_err = 1'b1;
               end
            end
         end else begin
            exp_pc = 1'b0; exp_rw = 1'b0; exp_m2r = 1'b0;
         end
         checks++;
         if (PCSrcW !== exp_pc) begin
            errors++; $display("FAIL %s pcsrc_w k=%0d got=%b exp=%b", tag, k, PCSrcW, exp_pc);
         end
         checks++;
         if (RegWriteW !== exp_rw) begin
            errors++; $display("FAIL %s regwrite_w k=%0d got=%b exp=%b", tag, k, RegWriteW, exp_rw);
         end
         checks++;
         if (MemtoRegW !== exp_m2r) begin
            errors++; $display("FAIL %s memtoreg_w k=%0d got=%b exp=%b", tag, k, MemtoRegW, exp_m2r);
         end
         checks++;
         if (ALUOutW !== exp_alu) begin
            errors++; $display("FAIL %s aluout_w k=%0d got=%h exp=%h", tag, k, ALUOutW, exp_alu);
         end
         checks++;
         if (WA3W !== exp_wa) begin
            errors++; $display("FAIL %s wa3_w k=%0d got=%h exp=%h", tag, k, WA3W, exp_wa);
         end
         checks++;
         if (ReadDataW !== exp_rd) begin
            errors++; $display("FAIL %s readdata_w k=%0d got=%h exp=%h", tag, k, ReadDataW, exp_rd);
         end
         checks++;
         if (MemErr !== exp_err) begin
            errors++; $display("FAIL %s mem_err k=%0d got=%b exp=%b", tag, k, MemErr, exp_err);
         end
      end
      checks++;
      if (hs != (acc ? 1 : 0)) begin
         errors++;
         $display("FAIL %s handshakes got=%0d exp=%0d", tag, hs, acc ? 1 : 0);
      end
      MemReqReady  = 1'b0;
      MemRespValid = 1'b0;
   endtask

   task automatic check_w_zero(input string tag);
      checks++;
      if ({PCSrcW, RegWriteW, MemtoRegW, MemErr} !== 4'b0 || ReadDataW !== '0 ||
          ALUOutW !== '0 || WA3W !== '0) begin
         errors++;
         $display("FAIL %s w_zero got=%b%b%b%b %h %h %h exp=all zero", tag, PCSrcW, RegWriteW,
                  MemtoRegW, MemErr, ReadDataW, ALUOutW, WA3W);
      end
      exp_pc = 0; exp_rw = 0; exp_m2r = 0; exp_err = 0;
      exp_alu = '0; exp_rd = '0; exp_wa = '0;
   endtask

   task automatic test_reset();
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      // A pending load with ready high must still be suppressed by reset.
      MemtoRegM = 1'b1; RegWriteM = 1'b1; ALUResultM = 32'h55; WA3M = 4'h7;
      MemReqReady = 1'b1;
      @(negedge CLK);
      checks++;
      if (MemReqValid !== 1'b0 || StallM !== 1'b0) begin
         errors++;
         $display("FAIL reset comb got=%b/%b exp=0/0", MemReqValid, StallM);
      end
      @(posedge CLK);
      #1;
      check_w_zero("reset");
      RESET = 1'b0;
      MemtoRegM = 1'b0; RegWriteM = 1'b0; MemReqReady = 1'b0;
   endtask

   task automatic test_alu();
      do_instr(0, 1, 0, 0, 32'h10, $urandom, 4'h3, 0, 0, 32'h0, 0, "alu");
   endtask

   task automatic test_store_wait();
      do_instr(0, 0, 0, 1, 32'h100, 32'hCAFEF00D, 4'h0, 2, 0, 32'h0, 0, "store_wait");
   endtask

   task automatic test_load();
      do_instr(0, 1, 1, 0, 32'h200, 32'h0, 4'h5, 0, 2, 32'h12345678, 0, "load");
   endtask

   task automatic test_timeout();
      do_instr(0, 1, 1, 0, 32'h300, 32'h0, 4'h6, 0, TO + 3, 32'hDEADBEEF, 0, "timeout");
      do_instr(0, 1, 0, 0, 32'h44, 32'h0, 4'h1, 0, 0, 32'h0, 1, "spurious");
   endtask

   task automatic test_back_to_back();
      do_instr(0, 1, 1, 0, 32'h400, 32'h0, 4'h8, 0, 1, 32'h11112222, 0, "b2b_first");
      do_instr(0, 1, 1, 0, 32'h404, 32'h0, 4'h9, 0, 1, 32'h33334444, 0, "b2b_second");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)),
                  $urandom, 0, "random");
      end
   endtask

   task automatic test_reset_mid_resp();
      // Make sure MemErr is set, so that clearing it on reset is observable.
      do_instr(0, 1, 1, 0, 32'h500, 32'h0, 4'h2, 0, TO, 32'h0, 0, "pre_reset_timeout");
      PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
      ALUResultM = 32'h600; WA3M = 4'hA; MemReqReady = 1'b1; MemRespValid = 1'b0;
      @(posedge CLK);
      #1;
      MemReqReady = 1'b0;
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (MemReqValid !== 1'b0 || StallM !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_resp comb got=%b/%b exp=0/0", MemReqValid, StallM);
      end
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_w_zero("reset_mid_resp");
      // The late response must not write ReadDataW.
      do_instr(0, 0, 0, 0, 32'h77, 32'h0, 4'h4, 0, 0, 32'h0, 1, "late_resp");
   endtask

   initial begin
      RESET = 1'b1;
      PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
      ALUResultM = '0; WriteDataM = '0; WA3M = '0;
      MemReqReady = 0; MemRespValid = 0; MemRData = '0;
      exp_pc = 0; exp_rw = 0; exp_m2r = 0; exp_err = 0;
      exp_alu = '0; exp_rd = '0; exp_wa = '0;
      test_reset();
      test_alu();
      test_store_wait();
      test_load();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
